// File: rtl/div_unit_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_unit_pkg
// | Shared encodings for the EX-stage divider: FSM states, width and funct codes.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
package div_unit_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] EXE_DIV  = 6'b011010;
  localparam logic [5:0] EXE_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

endpackage : div_unit_pkg
`default_nettype wire

// File: rtl/div_unit_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_unit_if
// | Request/result bundle between the EX-stage controller and the divider.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
interface div_unit_if #(
  parameter int DATA_W = div_unit_pkg::DATA_W_DEF
) ();

  logic              start;
  logic              is_signed;
  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              cancel;
  logic              stall;
  logic              ready;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, is_signed, opa, opb, cancel,
    input  stall, ready, hi, lo
  );

  modport slave (
    input  start, is_signed, opa, opb, cancel,
    output stall, ready, hi, lo
  );

endinterface : div_unit_if
`default_nettype wire

// File: rtl/div_unit_step.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_step
// | One combinational radix-2 restoring division step.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module div_step #(
  parameter int DATA_W = 32
) (
  input  wire logic [DATA_W-1:0] i_rem,
  input  wire logic [DATA_W-1:0] i_q,
  input  wire logic [DATA_W-1:0] i_divisor,
  output logic      [DATA_W-1:0] o_rem,
  output logic      [DATA_W-1:0] o_q
);

  logic [DATA_W:0] w_shift;
  logic [DATA_W:0] w_diff;
  logic            w_fits;

  // The running remainder is always below the divisor, so the shifted value fits
  // in DATA_W+1 bits and the top bit of the difference is exactly the borrow.
  assign w_shift = {i_rem, i_q[DATA_W-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_fits  = ~w_diff[DATA_W];

  assign o_rem = w_fits ? w_diff[DATA_W-1:0] : w_shift[DATA_W-1:0];
  assign o_q   = {i_q[DATA_W-2:0], w_fits};

endmodule : div_step
`default_nettype wire

// File: rtl/div_unit.sv
`default_nettype none
// +-----------------------------------------------------------------------------
// | div_unit
// | Multi-cycle signed/unsigned restoring divider; stalls EX until HI/LO ready.
// | Revision: 1.0
// +-----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input wire logic  clk,
  input wire logic  resetn,
  div_unit_if.slave bus
);

  localparam int               c_CNT_W = $clog2(DATA_W) + 1;
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(DATA_W - 1);

  div_state_e         r_state;
  div_state_e         w_state_nxt;
  logic [c_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_rem;
  logic [DATA_W-1:0]  r_q;
  logic [DATA_W-1:0]  r_div;
  logic [DATA_W-1:0]  r_raw_a;
  logic [DATA_W-1:0]  r_hi;
  logic [DATA_W-1:0]  r_lo;
  logic               r_sign_q;
  logic               r_sign_r;
  logic               r_dbz;

  logic               w_sa;
  logic               w_sb;
  logic               w_accept;
  logic               w_last;
  logic [DATA_W-1:0]  w_rem_nxt;
  logic [DATA_W-1:0]  w_q_nxt;
  logic [DATA_W-1:0]  w_res_hi;
  logic [DATA_W-1:0]  w_res_lo;

  assign w_sa     = bus.is_signed & bus.opa[DATA_W-1];
  assign w_sb     = bus.is_signed & bus.opb[DATA_W-1];
  assign w_accept = (r_state == DIV_IDLE) & bus.start & ~bus.cancel;
  assign w_last   = (r_state == DIV_BUSY) & (r_cnt == c_LAST) & ~bus.cancel;

  div_step #(.DATA_W(DATA_W)) u_step (
    .i_rem     (r_rem),
    .i_q       (r_q),
    .i_divisor (r_div),
    .o_rem     (w_rem_nxt),
    .o_q       (w_q_nxt)
  );

  // Result is formed from the final step so hi/lo are already valid in DONE.
  assign w_res_lo = r_dbz ? '1      : (r_sign_q ? -w_q_nxt   : w_q_nxt);
  assign w_res_hi = r_dbz ? r_raw_a : (r_sign_r ? -w_rem_nxt : w_rem_nxt);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= DIV_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    bus.ready   = 1'b0;
    bus.stall   = w_accept | (r_state == DIV_BUSY);
    case (r_state)
      DIV_IDLE: if (bus.start)      w_state_nxt = DIV_BUSY;
      DIV_BUSY: if (r_cnt == c_LAST) w_state_nxt = DIV_DONE;
      DIV_DONE: begin
        bus.ready   = ~bus.cancel;
        w_state_nxt = DIV_IDLE;
      end
      default:  w_state_nxt = DIV_IDLE;
    endcase
    if (bus.cancel) w_state_nxt = DIV_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cnt    <= '0;
      r_rem    <= '0;
      r_q      <= '0;
      r_div    <= '0;
      r_raw_a  <= '0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      if (w_accept) begin
        r_cnt    <= '0;
        r_rem    <= '0;
        r_q      <= w_sa ? -bus.opa : bus.opa;
        r_div    <= w_sb ? -bus.opb : bus.opb;
        r_raw_a  <= bus.opa;
        r_sign_q <= w_sa ^ w_sb;
        r_sign_r <= w_sa;
        r_dbz    <= (bus.opb == '0);
      end else if (r_state == DIV_BUSY) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= w_rem_nxt;
        r_q   <= w_q_nxt;
      end
      if (w_last) begin
        r_hi <= w_res_hi;
        r_lo <= w_res_lo;
      end
    end
  end

  assign bus.hi = r_hi;
  assign bus.lo = r_lo;

endmodule : div_unit
`default_nettype wire
